btn_step_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 13 +
 rtl/btn_debounce_bit.sv | 73 +++++++
 rtl/btn_step_conditioner.sv | 86 ++++++++
 tb/tb_btn_step_conditioner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants and helpers for the button conditioner.
// Sizes counters from the largest value they must hold.
package btn_pkg;

    localparam int BTN_WIDTH        = 12;
    localparam int STEP_BIT_DEFAULT = 0;

    // Bits needed to count 0..n-1, never less than one
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_bit.sv
// One button channel: synchroniser, stability counter,
// debounced level and registered press/release pulses.
module btn_debounce_bit
    import btn_pkg::*;
#(
    parameter int STABLE_TICKS = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CW = cnt_width(STABLE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic          r_meta;
    logic          r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          w_diff;
    logic          w_flip;

    assign w_diff = r_sync ^ r_level;
    assign w_flip = i_tick & w_diff & (r_cnt == LAST);

    // Two-flop synchroniser for the raw asynchronous input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
        end
    end

    // Count consecutive ticks of disagreement; any agreement restarts it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            if (!w_diff || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Flip the level once qualified and flag the edge direction
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_level   <= r_level ^ w_flip;
            r_press   <= w_flip & ~r_level;
            r_release <= w_flip & r_level;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/btn_step_conditioner.sv
// Debounces the board buttons and derives the CPU step enable,
// free-running in run mode or one pulse per press in step mode.
module btn_step_conditioner
    import btn_pkg::*;
#(
    parameter int WIDTH        = BTN_WIDTH,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 20,
    parameter int STEP_BIT     = STEP_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_in,
    input  logic             step_mode,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic             cpu_step
);

    logic w_tick;
    logic r_mode_meta;
    logic r_mode_s;
    logic r_cpu_step;

    generate
        if (TICK_DIV <= 1) begin : g_nodiv
            assign w_tick = 1'b1;
        end else begin : g_div
            localparam int PW = cnt_width(TICK_DIV);
            localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);

            logic [PW-1:0] r_pcnt;

            assign w_tick = (r_pcnt == TOP);

            // Sample prescaler shared by every channel
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pcnt <= '0;
                end else begin
                    r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
                end
            end
        end
    endgenerate

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_ch
            btn_debounce_bit #(
                .STABLE_TICKS(STABLE_TICKS)
            ) u_bit (
                .i_clk    (clk),
                .i_rst_n  (rst_n),
                .i_tick   (w_tick),
                .i_btn    (btn_in[g]),
                .o_level  (btn_level[g]),
                .o_press  (btn_press[g]),
                .o_release(btn_release[g])
            );
        end
    endgenerate

    // Synchronise the mode switch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_meta <= 1'b0;
            r_mode_s    <= 1'b0;
        end else begin
            r_mode_meta <= step_mode;
            r_mode_s    <= r_mode_meta;
        end
    end

    // Run mode steps every cycle; step mode echoes the step press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_step <= 1'b0;
        end else begin
            r_cpu_step <= r_mode_s ? btn_press[STEP_BIT] : 1'b1;
        end
    end

    assign cpu_step = r_cpu_step;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Bench for btn_step_conditioner: two instances (TICK_DIV=1/STABLE=4
// and TICK_DIV=3/STABLE=2) checked every cycle against a reference.
module tb_btn_step_conditioner;

    localparam int W   = 12;
    localparam int TD0 = 1;
    localparam int ST0 = 4;
    localparam int TD1 = 3;
    localparam int ST1 = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] btn_in = '0;
    logic         step_mode = 1'b0;

    logic [W-1:0] lvl0, prs0, rel0;
    logic [W-1:0] lvl1, prs1, rel1;
    logic         stp0, stp1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_step_conditioner #(
        .WIDTH(W), .TICK_DIV(TD0), .STABLE_TICKS(ST0), .STEP_BIT(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .step_mode(step_mode),
        .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0),
        .cpu_step(stp0)
    );

    btn_step_conditioner #(
        .WIDTH(W), .TICK_DIV(TD1), .STABLE_TICKS(ST1), .STEP_BIT(0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .step_mode(step_mode),
        .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1),
        .cpu_step(stp1)
    );

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: input seen two edges late; on each sample tick a channel
    // whose input has disagreed with its level for st ticks in a row flips.
    logic [W-1:0] m_s1, m_s2;
    logic         m_md1, m_md2;
    logic [W-1:0] m_lvl [2];
    logic [W-1:0] m_prs [2];
    logic [W-1:0] m_rel [2];
    logic         m_stp [2];
    int           m_run [2][W];
    int           m_cyc;

    always @(posedge clk) begin
        int  td;
        int  st;
        logic tick;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_md1 = 0; m_md2 = 0; m_cyc = 0;
            for (int k = 0; k < 2; k++) begin
                m_lvl[k] = '0; m_prs[k] = '0; m_rel[k] = '0; m_stp[k] = 0;
                for (int i = 0; i < W; i++) m_run[k][i] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                td = (k == 0) ? TD0 : TD1;
                st = (k == 0) ? ST0 : ST1;
                tick = ((m_cyc % td) == td - 1);
                m_stp[k] = m_md2 ? m_prs[k][0] : 1'b1;
                m_prs[k] = '0;
                m_rel[k] = '0;
                if (tick) begin
                    for (int i = 0; i < W; i++) begin
                        if (m_s2[i] != m_lvl[k][i]) begin
                            m_run[k][i]++;
                            if (m_run[k][i] == st) begin
                                m_run[k][i] = 0;
                                if (m_lvl[k][i]) m_rel[k][i] = 1'b1;
                                else m_prs[k][i] = 1'b1;
                                m_lvl[k][i] = ~m_lvl[k][i];
                            end
                        end else begin
                            m_run[k][i] = 0;
                        end
                    end
                end
            end
            m_s2 = m_s1; m_s1 = btn_in;
            m_md2 = m_md1; m_md1 = step_mode;
            m_cyc++;
        end
        #1;
        chk("lvl0", lvl0, m_lvl[0]);
        chk("prs0", prs0, m_prs[0]);
        chk("rel0", rel0, m_rel[0]);
        chk("stp0", {11'b0, stp0}, {11'b0, m_stp[0]});
        chk("lvl1", lvl1, m_lvl[1]);
        chk("prs1", prs1, m_prs[1]);
        chk("rel1", rel1, m_rel[1]);
        chk("stp1", {11'b0, stp1}, {11'b0, m_stp[1]});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: reset with every button held
        btn_in = '1;
        cyc(3);
        chk("t1_rst_lvl", lvl0, 12'h000);
        chk("t1_rst_prs", prs0, 12'h000);
        chk("t1_rst_stp", {11'b0, stp0}, 12'h000);
        rst_n = 1'b1;
        cyc(1); chk("t1_step_on", {11'b0, stp0}, 12'h001);
        cyc(4); chk("t1_lvl_e5", lvl0, 12'h000);
        cyc(1); chk("t1_lvl_e6", lvl0, 12'hFFF);
        chk("t1_prs_e6", prs0, 12'hFFF);
        cyc(1); chk("t1_prs_e7", prs0, 12'h000);
        btn_in = '0;
        cyc(10);

        // 2: clean press and release of channel 0
        btn_in = 12'h001;
        cyc(5); chk("t2_lvl_e5", lvl0, 12'h000);
        cyc(1); chk("t2_lvl_e6", lvl0, 12'h001);
        chk("t2_prs_e6", prs0, 12'h001);
        cyc(1); chk("t2_prs_e7", prs0, 12'h000);
        cyc(13);
        btn_in = 12'h000;
        cyc(5); chk("t2_rlvl_e5", lvl0, 12'h001);
        cyc(1); chk("t2_rlvl_e6", lvl0, 12'h000);
        chk("t2_rel_e6", rel0, 12'h001);
        cyc(1); chk("t2_rel_e7", rel0, 12'h000);
        cyc(4);

        // 3: bouncing channel 3, then a clean hold
        for (int j = 0; j < 6; j++) begin
            btn_in[3] = (j % 2 == 0);
            cyc(2);
        end
        chk("t3_no_lvl", lvl0, 12'h000);
        btn_in[3] = 1'b1;
        cyc(5); chk("t3_prs_e5", prs0, 12'h000);
        cyc(1); chk("t3_prs_e6", prs0, 12'h008);
        chk("t3_lvl_e6", lvl0, 12'h008);
        btn_in = '0;
        cyc(10);

        // 4: single-step mode, three presses, back to run
        step_mode = 1'b1;
        cyc(4); chk("t4_step_off", {11'b0, stp0}, 12'h000);
        for (int p = 0; p < 3; p++) begin
            btn_in[0] = 1'b1;
            cyc(6); chk("t4_prs", prs0, 12'h001);
            chk("t4_stp_e6", {11'b0, stp0}, 12'h000);
            cyc(1); chk("t4_stp_e7", {11'b0, stp0}, 12'h001);
            cyc(1); chk("t4_stp_e8", {11'b0, stp0}, 12'h000);
            cyc(4);
            btn_in[0] = 1'b0;
            cyc(10);
        end
        step_mode = 1'b0;
        cyc(2); chk("t4_run_e2", {11'b0, stp0}, 12'h000);
        cyc(1); chk("t4_run_e3", {11'b0, stp0}, 12'h001);
        cyc(2);

        // 5: reset in the middle of qualification
        btn_in = 12'h020;
        cyc(4); chk("t5_pre_lvl", lvl0, 12'h000);
        chk("t5_pre_prs", prs0, 12'h000);
        rst_n = 1'b0;
        cyc(1); chk("t5_in_rst", lvl0, 12'h000);
        rst_n = 1'b1;
        cyc(5); chk("t5_lvl_e5", lvl0, 12'h000);
        cyc(1); chk("t5_prs_e6", prs0, 12'h020);
        chk("t5_lvl_e6", lvl0, 12'h020);
        cyc(2);

        // 6a: prescaled instance, clean rise of channel 11
        btn_in = '0;
        do_reset();
        cyc(4); btn_in[11] = 1'b1;
        cyc(5); chk("t6a_e9", lvl1, 12'h000);
        cyc(2); chk("t6a_e11", lvl1, 12'h000);
        cyc(1); chk("t6a_e12", lvl1, 12'h800);

        // 6b: same, with the input low at exactly one tick
        btn_in = '0;
        do_reset();
        cyc(4); btn_in[11] = 1'b1;
        cyc(5); btn_in[11] = 1'b0;
        cyc(1); btn_in[11] = 1'b1;
        cyc(2); chk("t6b_e12", lvl1, 12'h000);
        cyc(5); chk("t6b_e17", lvl1, 12'h000);
        cyc(1); chk("t6b_e18", lvl1, 12'h800);
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
